// File: rtl/csr_counters_if.sv
// CSR access bus between the execute stage and csr_counters.
//   wen     : write strobe; wdata is the final value
//   addr    : 12-bit CSR address
//   wdata   : write data
//   rdata   : combinational read data for addr
//   illegal : addr unimplemented, or write to a read-only CSR
interface csr_counters_if;
  logic        wen;
  logic [11:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        illegal;

  modport master (output wen, addr, wdata, input rdata, illegal);
  modport slave  (input wen, addr, wdata, output rdata, illegal);
endinterface

// File: rtl/csr_counters.sv
// Machine-mode CSR unit: ID registers, mcycle/minstret, NUM_HPM hardware
// performance counters with event selectors, mcountinhibit and the
// read-only user shadows (0xCxx).
//   clock      : rising-edge clock
//   reset      : asynchronous, active-low
//   bus        : CSR access (wen/addr/wdata in, rdata/illegal out)
//   is_instret : one instruction retires this cycle
//   halt       : core halted, freezes every counter
//   events     : per-cycle event pulses for the hpm counters
module csr_counters #(
  parameter int unsigned NUM_HPM = 4,
  parameter int unsigned EVENT_W = 8,
  parameter int unsigned CNT_W   = 64,
  parameter logic [31:0] HARTID  = 32'h0
) (
  input  logic               clock,
  input  logic               reset,
  csr_counters_if.slave      bus,
  input  logic               is_instret,
  input  logic               halt,
  input  logic [EVENT_W-1:0] events
);

  localparam int unsigned HN    = (NUM_HPM == 0) ? 1 : NUM_HPM;
  localparam int unsigned SEL_W = $clog2(EVENT_W + 1);
  // CY, IR and one bit per implemented hpm counter
  localparam logic [31:0] INH_MASK =
    32'h5 | 32'(((64'd1 << NUM_HPM) - 64'd1) << 3);
  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] cyc_q;
  logic [CNT_W-1:0] ins_q;
  logic [CNT_W-1:0] hpm_q [HN];
  logic [SEL_W-1:0] sel_q [HN];
  logic [31:0]      inh_q;

  logic          hit, ro;
  logic [31:0]   data;
  logic          we_cy_lo, we_cy_hi, we_ir_lo, we_ir_hi, we_inh;
  logic [HN-1:0] we_hpm_lo, we_hpm_hi, we_sel;
  logic [HN-1:0] ev_hit;
  logic          cy_inc, ir_inc;
  logic [HN-1:0] hpm_inc;

  // Counters are viewed as 64 bits so bits at or above CNT_W read 0
  // and absorb writes.
  function automatic logic [31:0] rd_half(input logic [CNT_W-1:0] cur,
                                          input logic hi);
    logic [63:0] v;
    v = 64'(cur);
    return hi ? v[63:32] : v[31:0];
  endfunction

  function automatic logic [CNT_W-1:0] wr_half(input logic [CNT_W-1:0] cur,
                                               input logic hi,
                                               input logic [31:0] d);
    logic [63:0] v;
    v = 64'(cur);
    if (hi) v[63:32] = d;
    else    v[31:0]  = d;
    return v[CNT_W-1:0];
  endfunction

  always_comb begin
    hit       = 1'b0;
    ro        = 1'b0;
    data      = '0;
    we_cy_lo  = 1'b0;
    we_cy_hi  = 1'b0;
    we_ir_lo  = 1'b0;
    we_ir_hi  = 1'b0;
    we_inh    = 1'b0;
    we_hpm_lo = '0;
    we_hpm_hi = '0;
    we_sel    = '0;
    case (bus.addr)
      12'h301: begin hit = 1'b1; data = 32'h4000_0010; end
      12'hF11: begin hit = 1'b1; ro = 1'b1; data = 32'h6265_6B61; end
      12'hF12: begin hit = 1'b1; ro = 1'b1; data = 32'h0531_8008; end
      12'hF13: begin hit = 1'b1; ro = 1'b1; end
      12'hF14: begin hit = 1'b1; ro = 1'b1; data = HARTID; end
      12'h320: begin hit = 1'b1; data = inh_q; we_inh = bus.wen; end
      12'hB00: begin hit = 1'b1; data = rd_half(cyc_q, 1'b0); we_cy_lo = bus.wen; end
      12'hB80: begin hit = 1'b1; data = rd_half(cyc_q, 1'b1); we_cy_hi = bus.wen; end
      12'hB02: begin hit = 1'b1; data = rd_half(ins_q, 1'b0); we_ir_lo = bus.wen; end
      12'hB82: begin hit = 1'b1; data = rd_half(ins_q, 1'b1); we_ir_hi = bus.wen; end
      12'hC00: begin hit = 1'b1; ro = 1'b1; data = rd_half(cyc_q, 1'b0); end
      12'hC80: begin hit = 1'b1; ro = 1'b1; data = rd_half(cyc_q, 1'b1); end
      12'hC02: begin hit = 1'b1; ro = 1'b1; data = rd_half(ins_q, 1'b0); end
      12'hC82: begin hit = 1'b1; ro = 1'b1; data = rd_half(ins_q, 1'b1); end
      default: ;
    endcase
    for (int unsigned i = 0; i < NUM_HPM; i++) begin
      if (bus.addr == 12'(12'h323 + i)) begin
        hit = 1'b1; data = 32'(sel_q[i]); we_sel[i] = bus.wen;
      end
      if (bus.addr == 12'(12'hB03 + i)) begin
        hit = 1'b1; data = rd_half(hpm_q[i], 1'b0); we_hpm_lo[i] = bus.wen;
      end
      if (bus.addr == 12'(12'hB83 + i)) begin
        hit = 1'b1; data = rd_half(hpm_q[i], 1'b1); we_hpm_hi[i] = bus.wen;
      end
      if (bus.addr == 12'(12'hC03 + i)) begin
        hit = 1'b1; ro = 1'b1; data = rd_half(hpm_q[i], 1'b0);
      end
      if (bus.addr == 12'(12'hC83 + i)) begin
        hit = 1'b1; ro = 1'b1; data = rd_half(hpm_q[i], 1'b1);
      end
    end
    bus.rdata   = data;
    bus.illegal = !hit || (ro && bus.wen);
  end

  // SEL outside 1..EVENT_W matches no event and never counts.
  always_comb begin
    ev_hit = '0;
    for (int unsigned i = 0; i < HN; i++)
      for (int unsigned j = 0; j < EVENT_W; j++)
        if (sel_q[i] == SEL_W'(j + 1)) ev_hit[i] = events[j];
  end

  always_comb begin
    cy_inc  = !halt && !inh_q[0];
    ir_inc  = is_instret && !halt && !inh_q[2];
    hpm_inc = '0;
    for (int unsigned i = 0; i < HN; i++)
      hpm_inc[i] = ev_hit[i] && !halt && !inh_q[3 + i];
  end

  // A write to either half of a counter wins over its increment.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cyc_q <= '0;
      ins_q <= '0;
      inh_q <= '0;
      for (int unsigned i = 0; i < HN; i++) begin
        hpm_q[i] <= '0;
        sel_q[i] <= '0;
      end
    end else begin
      if (we_cy_lo || we_cy_hi) cyc_q <= wr_half(cyc_q, we_cy_hi, bus.wdata);
      else if (cy_inc)          cyc_q <= cyc_q + ONE;
      if (we_ir_lo || we_ir_hi) ins_q <= wr_half(ins_q, we_ir_hi, bus.wdata);
      else if (ir_inc)          ins_q <= ins_q + ONE;
      if (we_inh) inh_q <= bus.wdata & INH_MASK;
      for (int unsigned i = 0; i < HN; i++) begin
        if (we_hpm_lo[i] || we_hpm_hi[i])
          hpm_q[i] <= wr_half(hpm_q[i], we_hpm_hi[i], bus.wdata);
        else if (hpm_inc[i])
          hpm_q[i] <= hpm_q[i] + ONE;
        if (we_sel[i]) sel_q[i] <= bus.wdata[SEL_W-1:0];
      end
    end
  end

endmodule

// File: tb/tb_csr_counters.sv
module tb_csr_counters;
  localparam int unsigned NUM_HPM = 4;
  localparam int unsigned EVENT_W = 8;
  localparam int unsigned CNT_W   = 64;
  localparam logic [31:0] HARTID  = 32'h0000_0007;
  localparam int unsigned SEL_W   = $clog2(EVENT_W + 1);

  logic               clock = 1'b0;
  logic               reset;
  logic               is_instret;
  logic               halt;
  logic [EVENT_W-1:0] events;

  csr_counters_if bus ();

  csr_counters #(
    .NUM_HPM(NUM_HPM),
    .EVENT_W(EVENT_W),
    .CNT_W  (CNT_W),
    .HARTID (HARTID)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .bus       (bus.slave),
    .is_instret(is_instret),
    .halt      (halt),
    .events    (events)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Reference model: counters indexed by CSR number low bits
  // (0 = cycle, 2 = instret, 3+i = hpm i), 64-bit arithmetic.
  longint unsigned m_cnt [32];
  int unsigned     m_sel [32];
  int unsigned     m_inh;

  logic [11:0] alist [24] = '{
    12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hB03, 12'hB04, 12'hB05, 12'hB06,
    12'hB83, 12'hB86, 12'hC00, 12'hC80, 12'hC02, 12'hC82, 12'hC03, 12'hC86,
    12'h320, 12'h323, 12'h326, 12'h301, 12'hF11, 12'hF14, 12'hB07, 12'hC81};

  function automatic bit implemented(int k);
    return k == 0 || k == 2 || (k >= 3 && k < 3 + int'(NUM_HPM));
  endfunction

  function automatic longint unsigned cmask();
    return (CNT_W >= 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << CNT_W) - 64'd1);
  endfunction

  task automatic m_reset();
    for (int k = 0; k < 32; k++) begin
      m_cnt[k] = 0;
      m_sel[k] = 0;
    end
    m_inh = 0;
  endtask

  function automatic void m_read(input logic [11:0] a, input logic w,
                                 output logic [31:0] d, output logic ill);
    int k;
    logic [63:0] v;
    d   = 32'h0;
    ill = 1'b1;
    k   = int'(a[4:0]);
    if (a == 12'h301) begin d = 32'h4000_0010; ill = 1'b0; end
    else if (a == 12'hF11) begin d = "beka";        ill = w; end
    else if (a == 12'hF12) begin d = 32'h0531_8008; ill = w; end
    else if (a == 12'hF13) begin d = 32'h0;         ill = w; end
    else if (a == 12'hF14) begin d = HARTID;        ill = w; end
    else if (a == 12'h320) begin d = m_inh;         ill = 1'b0; end
    else if (a >= 12'h323 && a <= 12'h33F && implemented(int'(a - 12'h320))) begin
      d = m_sel[a - 12'h320]; ill = 1'b0;
    end else if ((a[11:8] == 4'hB || a[11:8] == 4'hC) && a[6:5] == 2'b00
                 && implemented(k)) begin
      v   = m_cnt[k];
      d   = a[7] ? v[63:32] : v[31:0];
      ill = (a[11:8] == 4'hC) && w;
    end
  endfunction

  // Computes the next model state from the current one, then commits it
  // at the rising edge.
  task automatic model_step(input logic w, input logic [11:0] a,
                            input logic [31:0] wd, input logic ins,
                            input logic hlt, input logic [EVENT_W-1:0] ev);
    longint unsigned nxt [32];
    int unsigned     nsel [32];
    int unsigned     ninh;
    bit              c;
    int              k;
    ninh = m_inh;
    for (int i = 0; i < 32; i++) begin
      nxt[i]  = m_cnt[i];
      nsel[i] = m_sel[i];
      if (implemented(i)) begin
        if (i == 0)      c = 1'b1;
        else if (i == 2) c = ins;
        else             c = (m_sel[i] >= 1 && m_sel[i] <= EVENT_W) ? ev[m_sel[i] - 1] : 1'b0;
        if (!hlt && !m_inh[i] && c) nxt[i] = (m_cnt[i] + 1) & cmask();
      end
    end
    k = int'(a[4:0]);
    if (w && a[11:8] == 4'hB && a[6:5] == 2'b00 && implemented(k)) begin
      if (a[7]) nxt[k] = ((m_cnt[k] % 64'h1_0000_0000) + (longint'(wd) << 32)) & cmask();
      else      nxt[k] = ((m_cnt[k] >> 32) << 32) + longint'(wd);
    end
    if (w && a == 12'h320) begin
      ninh = 0;
      for (int i = 0; i < 32; i++)
        if (implemented(i) && wd[i]) ninh = ninh | (32'd1 << i);
    end
    if (w && a >= 12'h323 && a <= 12'h33F && implemented(int'(a - 12'h320)))
      nsel[a - 12'h320] = wd % (32'd1 << SEL_W);
    @(posedge clock);
    m_cnt = nxt;
    m_sel = nsel;
    m_inh = ninh;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic peek(input string tag, input logic [11:0] a, input logic [31:0] exp);
    bus.wen  = 1'b0;
    bus.addr = a;
    #1;
    chk(tag, bus.rdata, exp);
  endtask

  task automatic peek_ill(input string tag, input logic [11:0] a, input logic exp);
    bus.wen  = 1'b1;
    bus.addr = a;
    #1;
    chk(tag, 32'(bus.illegal), 32'(exp));
  endtask

  // One clock: drive at the falling edge, check combinational outputs
  // against the model, advance model and DUT together.
  task automatic cycle(input string tag, input logic w, input logic [11:0] a,
                       input logic [31:0] wd, input logic ins, input logic hlt,
                       input logic [EVENT_W-1:0] ev);
    logic [31:0] ed;
    logic        ei;
    bus.wen    = w;
    bus.addr   = a;
    bus.wdata  = wd;
    is_instret = ins;
    halt       = hlt;
    events     = ev;
    #1;
    m_read(a, w, ed, ei);
    chk({tag, "_rdata"}, bus.rdata, ed);
    chk({tag, "_illegal"}, 32'(bus.illegal), 32'(ei));
    model_step(w, a, wd, ins, hlt, ev);
    @(negedge clock);
    bus.wen = 1'b0;
  endtask

  longint unsigned snap_cy, snap_ir;

  initial begin
    reset = 1'b0; bus.wen = 1'b0; bus.addr = 12'h0; bus.wdata = 32'h0;
    is_instret = 1'b0; halt = 1'b0; events = '0;
    m_reset();
    @(negedge clock); @(negedge clock);
    peek("in_reset_mcycle", 12'hB00, 32'h0);
    reset = 1'b1;

    // mcycle counts from 0 once reset is released; cycle shadow tracks it
    for (int n = 0; n < 5; n++) begin
      peek("mcycle_seq", 12'hB00, 32'(n));
      cycle("cycle_shadow", 1'b0, 12'hC00, 32'h0, 1'b0, 1'b0, '0);
    end
    peek("mvendorid", 12'hF11, 32'h6265_6B61);
    peek("mhartid", 12'hF14, HARTID);

    // all-ones wrap
    cycle("wr_mcycle", 1'b1, 12'hB00, 32'hFFFF_FFFF, 1'b0, 1'b0, '0);
    cycle("wr_mcycleh", 1'b1, 12'hB80, 32'hFFFF_FFFF, 1'b0, 1'b0, '0);
    peek("ones_lo", 12'hB00, 32'hFFFF_FFFF);
    peek("ones_hi", 12'hB80, 32'hFFFF_FFFF);
    cycle("wrap", 1'b0, 12'hB00, 32'h0, 1'b0, 1'b0, '0);
    peek("wrap_lo", 12'hB00, 32'h0);
    peek("wrap_hi", 12'hB80, 32'h0);

    // low-to-high carry
    cycle("wr_hi0", 1'b1, 12'hB80, 32'h0, 1'b0, 1'b0, '0);
    cycle("wr_lo1s", 1'b1, 12'hB00, 32'hFFFF_FFFF, 1'b0, 1'b0, '0);
    peek("pre_carry_hi", 12'hB80, 32'h0);
    cycle("carry", 1'b0, 12'hB80, 32'h0, 1'b0, 1'b0, '0);
    peek("carry_lo", 12'hB00, 32'h0);
    peek("carry_hi", 12'hB80, 32'h1);

    // hpm3 on events[1]
    cycle("wr_evt3", 1'b1, 12'h323, 32'd2, 1'b0, 1'b0, '0);
    for (int n = 0; n < 7; n++) cycle("ev1", 1'b0, 12'hB03, 32'h0, 1'b0, 1'b0, 8'h02);
    for (int n = 0; n < 3; n++) cycle("ev0", 1'b0, 12'hC03, 32'h0, 1'b0, 1'b0, 8'h01);
    peek("hpm3_count", 12'hB03, 32'd7);
    cycle("wr_evt3_9", 1'b1, 12'h323, 32'd9, 1'b0, 1'b0, '0);
    for (int n = 0; n < 5; n++) cycle("sel9", 1'b0, 12'hB03, 32'h0, 1'b0, 1'b0, 8'hFF);
    peek("hpm3_sel9", 12'hB03, 32'd7);
    peek("evt3_read", 12'h323, 32'd9);

    // inhibit CY and IR
    cycle("wr_inh", 1'b1, 12'h320, 32'h5, 1'b0, 1'b0, '0);
    snap_cy = m_cnt[0]; snap_ir = m_cnt[2];
    for (int n = 0; n < 10; n++) cycle("inh", 1'b0, 12'hB02, 32'h0, 1'b1, 1'b0, '0);
    peek("inh_cy_hold", 12'hB00, snap_cy[31:0]);
    peek("inh_ir_hold", 12'hB02, snap_ir[31:0]);
    cycle("clr_inh", 1'b1, 12'h320, 32'h0, 1'b0, 1'b0, '0);
    cycle("wr_evt4", 1'b1, 12'h324, 32'd1, 1'b0, 1'b0, '0);
    snap_cy = m_cnt[0]; snap_ir = m_cnt[2];
    for (int n = 0; n < 5; n++) cycle("halt", 1'b0, 12'hB04, 32'h0, 1'b1, 1'b1, 8'hFF);
    peek("halt_cy_hold", 12'hB00, snap_cy[31:0]);
    peek("halt_ir_hold", 12'hB02, snap_ir[31:0]);

    // illegal writes
    peek_ill("ill_c00", 12'hC00, 1'b1);
    cycle("w_c00", 1'b1, 12'hC00, 32'h1234, 1'b0, 1'b0, '0);
    peek_ill("ill_f12", 12'hF12, 1'b1);
    cycle("w_f12", 1'b1, 12'hF12, 32'h1234, 1'b0, 1'b0, '0);
    peek("marchid_kept", 12'hF12, 32'h0531_8008);
    peek_ill("ill_b10", 12'hB10, 1'b1);
    cycle("w_b10", 1'b1, 12'hB10, 32'h1234, 1'b0, 1'b0, '0);
    peek_ill("misa_legal", 12'h301, 1'b0);
    cycle("w_misa", 1'b1, 12'h301, 32'h0, 1'b0, 1'b0, '0);
    peek("misa_kept", 12'h301, 32'h4000_0010);
    cycle("rd_b01", 1'b0, 12'hB01, 32'h0, 1'b0, 1'b0, '0);
    cycle("rd_c81", 1'b0, 12'hC81, 32'h0, 1'b0, 1'b0, '0);

    // write to minstret wins over is_instret
    cycle("wr_minstret", 1'b1, 12'hB02, 32'h0000_ABCD, 1'b1, 1'b0, '0);
    peek("minstret_no_inc", 12'hB02, 32'h0000_ABCD);

    // asynchronous reset mid-count
    cycle("wr_cyh0", 1'b1, 12'hB80, 32'h0, 1'b0, 1'b0, '0);
    cycle("wr_cy1234", 1'b1, 12'hB00, 32'h1234, 1'b0, 1'b0, '0);
    peek("pre_reset", 12'hB00, 32'h1234);
    #1 reset = 1'b0;
    m_reset();
    peek("async_reset", 12'hB00, 32'h0);
    @(posedge clock);
    @(negedge clock);
    peek("reset_held", 12'hB00, 32'h0);
    peek("reset_inh", 12'h320, 32'h0);
    reset = 1'b1;
    cycle("resume", 1'b0, 12'hB00, 32'h0, 1'b0, 1'b0, '0);
    peek("resume_1", 12'hB00, 32'h1);

    // randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      logic [11:0] a;
      logic [31:0] wd;
      a  = ($urandom % 8 == 0) ? 12'($urandom) : alist[$urandom % 24];
      wd = ($urandom % 2 == 0) ? (32'hFFFF_FFF0 | ($urandom % 16)) : $urandom;
      if (a == 12'h320) wd = wd & 32'h0000_0078;
      cycle("rand", ($urandom % 6 == 0), a, wd, 1'($urandom), ($urandom % 16 == 0),
            EVENT_W'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
